// File: rtl/lut_table_loader.sv
// 1-bit-per-entry lookup table, filled by a stream of framed config words and
// read by a handshaked inference port with one cycle of latency.
module lut_table_loader #(
  parameter int IN_BITS = 8,
  parameter int CFG_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CFG_W-1:0]   cfg_data,
  input  logic               cfg_last,
  output logic               cfg_err,
  output logic               table_loaded,
  input  logic [IN_BITS-1:0] M0,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               M1,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int SEL_W = $clog2(CFG_W);
  localparam int CNT_W = IN_BITS - SEL_W;
  localparam int WORDS = 2 ** CNT_W;

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_eff_cnt;
  logic             r_cfg_err;
  logic             w_cfg_err_nxt;
  logic             w_wr_en;
  logic             w_in_acc;
  logic             r_m1;
  logic             r_out_valid;
  logic [CFG_W-1:0] r_mem [WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_cnt     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  // A word arriving outside LOADING starts a new load at index 0.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cfg_err_nxt = 1'b0;
    w_wr_en       = 1'b0;
    w_eff_cnt     = (r_state == LOADING) ? r_cnt : '0;
    if (cfg_valid) begin
      if (cfg_last != (w_eff_cnt == {CNT_W{1'b1}})) begin
        w_cfg_err_nxt = 1'b1;
        w_state_nxt   = EMPTY;
      end else begin
        w_wr_en = 1'b1;
        if (cfg_last) begin
          w_state_nxt = READY;
        end else begin
          w_state_nxt = LOADING;
          w_cnt_nxt   = w_eff_cnt + 1'b1;
        end
      end
    end
  end

  // Table storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_eff_cnt] <= cfg_data;
    end
  end

  assign w_in_acc = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m1        <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_in_acc) begin
      r_m1        <= r_mem[M0[IN_BITS-1:SEL_W]][M0[SEL_W-1:0]];
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign cfg_ready    = 1'b1;
  assign cfg_err      = r_cfg_err;
  assign table_loaded = (r_state == READY);
  assign in_ready     = (r_state == READY) & ~cfg_valid & (~r_out_valid | out_ready);
  assign M1           = r_m1;
  assign out_valid    = r_out_valid;

endmodule

// File: tb/tb_lut_table_loader.sv
// Randomized scoreboard bench for lut_table_loader: a table model built from
// the load-framing rules predicts every result; a monitor pops and compares.
module tb_lut_table_loader;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       cfg_err;
  logic       table_loaded;
  logic [7:0] M0;
  logic       in_valid;
  logic       in_ready;
  logic       M1;
  logic       out_valid;
  logic       out_ready;

  lut_table_loader #(.IN_BITS(8), .CFG_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .cfg_err(cfg_err), .table_loaded(table_loaded),
    .M0(M0), .in_valid(in_valid), .in_ready(in_ready),
    .M1(M1), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit         sb[$];
  bit [255:0] ref_table;
  bit         ref_loaded  = 0;
  bit         ref_loading = 0;
  int         ref_idx     = 0;
  logic [7:0] load_words [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: one result register, so out_valid must mirror queue occupancy.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", out_valid, (sb.size() != 0));
      if (out_valid && sb.size() != 0) begin
        chk("M1", M1, sb[0]);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send_word(input logic [7:0] d, input bit last, input bit iv, input logic [7:0] code);
    bit exp_err;
    cfg_valid = 1; cfg_data = d; cfg_last = last; in_valid = iv; M0 = code;
    @(negedge clk); #2;
    chk("in_ready_during_cfg", in_ready, 0);
    exp_err = 0;
    if (!ref_loading) ref_idx = 0;
    if (last != (ref_idx == 31)) begin
      exp_err = 1; ref_loading = 0; ref_loaded = 0;
    end else begin
      ref_table[ref_idx*8 +: 8] = d;
      if (last) begin ref_loaded = 1; ref_loading = 0; end
      else begin ref_loading = 1; ref_loaded = 0; ref_idx++; end
    end
    @(posedge clk); #1;
    cfg_valid = 0; cfg_last = 0; in_valid = 0;
    @(negedge clk); #2;
    chk("cfg_err", cfg_err, exp_err);
    chk("table_loaded", table_loaded, ref_loaded);
    @(posedge clk); #1;
    @(negedge clk); #2;
    chk("cfg_err_pulse_end", cfg_err, 0);
    @(posedge clk); #1;
  endtask

  task automatic load_table();
    for (int i = 0; i < 32; i++) send_word(load_words[i], (i == 31), 0, 8'h00);
  endtask

  task automatic step_infer(input bit iv, input logic [7:0] code, input bit ordy, output bit acc);
    bit exp_ir;
    in_valid = iv; M0 = code; out_ready = ordy;
    @(negedge clk); #2;
    exp_ir = ref_loaded && !cfg_valid && (sb.size() == 0 || ordy);
    chk("in_ready", in_ready, exp_ir);
    acc = iv && in_ready;
    if (acc) sb.push_back(ref_table[code]);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 8 && sb.size() != 0; k++) step_infer(0, 8'h00, 1, acc);
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic random_traffic(input int n);
    bit acc;
    for (int k = 0; k < n; k++)
      step_infer(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit   acc;
    int   idx;
    int   code1;
    rst_n = 0; cfg_valid = 0; cfg_data = 0; cfg_last = 0;
    M0 = 0; in_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_table_loaded", table_loaded, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_M1", M1, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Single hot bit at entry 0x24
    for (int i = 0; i < 32; i++) load_words[i] = 8'h00;
    load_words[4] = 8'h10;
    load_table();
    step_infer(1, 8'h24, 1, acc);
    chk("accept_0x24", acc, 1);
    step_infer(1, 8'h23, 1, acc);
    chk("accept_0x23", acc, 1);
    drain();

    // Early cfg_last on word 10
    for (int i = 0; i <= 10; i++) send_word(8'($urandom), (i == 10), 0, 8'h00);
    step_infer(1, 8'h05, 1, acc);

    // 32 words with no cfg_last: error on the last, then stay unloaded
    for (int i = 0; i < 32; i++) send_word(8'($urandom), 0, 0, 8'h00);
    repeat (3) step_infer(1, 8'($urandom), 1, acc);
    chk("empty_after_nolast", table_loaded, 0);

    // Random table, full-rate sweep, then backpressure hold
    for (int i = 0; i < 32; i++) load_words[i] = 8'($urandom);
    load_table();
    idx = 0;
    for (int k = 0; k < 300 && idx < 256; k++) begin
      step_infer(1, 8'(idx), 1, acc);
      if (acc) idx++;
    end
    chk("sweep_count", idx, 256);
    repeat (3) step_infer(1, 8'($urandom), 0, acc);
    drain();
    random_traffic(300);
    drain();

    // Pending result survives a reload that starts alongside an input
    code1 = 0;
    for (int c = 0; c < 256; c++) if (ref_table[c] && code1 == 0) code1 = c;
    if (!ref_table[code1]) begin
      load_words[0][0] = 1'b1;
      ref_table[0] = 1'b1;
    end
    step_infer(1, 8'(code1), 0, acc);
    chk("pending_accept", acc, 1);
    send_word(8'($urandom), 0, 1, 8'($urandom));
    for (int i = 1; i <= 15; i++) send_word(8'($urandom), 0, 0, 8'h00);
    chk("pending_still_valid", sb.size(), 1);

    // Asynchronous reset mid-load
    #2;
    rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_M1", M1, 0);
    chk("arst_table_loaded", table_loaded, 0);
    chk("arst_cfg_err", cfg_err, 0);
    sb.delete();
    ref_loaded = 0; ref_loading = 0;
    out_ready = 1;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) load_words[i] = 8'($urandom);
    load_table();
    random_traffic(150);
    drain();

    // Single-word load with cfg_last while READY is a framing error
    send_word(8'($urandom), 1, 0, 8'h00);
    step_infer(1, 8'($urandom), 1, acc);
    for (int i = 0; i < 32; i++) load_words[i] = 8'($urandom);
    load_table();
    random_traffic(100);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
